// File: rtl/iq_pkt_pkg.sv
// Shared constants, FSM encoding and packing helpers for the IQ UDP packetizer.
package iq_pkt_pkg;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    localparam int         HDR_WORDS = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR0    = 2'd1,
        HDR1    = 2'd2,
        PAYLOAD = 2'd3
    } pkt_state_e;

    // One packed IQ sample: I in the upper half, Q in the lower half.
    function automatic logic [31:0] pack_iq(input logic [15:0] i_s, input logic [15:0] q_s);
        return {i_s, q_s};
    endfunction

    // Second header word: magic, sticky overflow flag, payload sample count.
    function automatic logic [31:0] make_hdr1(input logic flag, input logic [15:0] n_words);
        return {HDR_MAGIC, flag, 7'd0, n_words};
    endfunction

endpackage

// File: rtl/iq_sample_fifo.sv
// First-word-fall-through sample FIFO; rd_data always shows the current head.
module iq_sample_fifo #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             wr_ok;
    logic             rd_ok;

    // full/empty come from the registered count, so a write while full is
    // refused even if a pop frees a slot in the same cycle.
    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/iq_udp_packetizer.sv
// IQ sample packetizer: buffers samples and emits header + payload packets.
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | waiting until the FIFO holds a full packet's worth
// HDR0    | presenting the sequence number word
// HDR1    | presenting magic / overflow flag / sample count word
// PAYLOAD | presenting FIFO head words until N have been accepted
module iq_udp_packetizer
    import iq_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 1024,
    parameter int CNT_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [15:0]           iq_i,
    input  logic [15:0]           iq_q,
    input  logic                  iq_valid,
    input  logic [CNT_W-1:0]      pkt_words,
    output logic [DATA_WIDTH-1:0] app_data,
    output logic [15:0]           app_len,
    output logic                  app_valid,
    input  logic                  app_ready,
    output logic [31:0]           seq_num,
    output logic [15:0]           overflow_count,
    output logic [CNT_W:0]        fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    pkt_state_e            state;
    pkt_state_e            state_nxt;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LVL_W-1:0]      level;
    logic                  wr_req;
    logic                  drop;
    logic [CNT_W-1:0]      n_cand;
    logic [CNT_W-1:0]      n_lat;
    logic [CNT_W-1:0]      remain;
    logic                  ovf_flag;
    logic [31:0]           seq_r;
    logic [31:0]           seq_nxt;
    logic [15:0]           ovf_cnt;
    logic                  start_pkt;
    logic                  hdr1_hs;
    logic                  pop;
    logic                  last_pop;

    assign wr_req     = enable && iq_valid;
    assign drop       = wr_req && fifo_full;
    assign n_cand     = (pkt_words == '0) ? CNT_W'(1) : pkt_words;
    assign seq_nxt    = seq_r + {31'd0, last_pop};
    assign seq_num    = seq_r;
    assign overflow_count = ovf_cnt;
    assign fifo_level = level[CNT_W:0];

    iq_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_req),
        .wr_data (pack_iq(iq_i, iq_q)),
        .rd_en   (pop && !fifo_empty),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake-side outputs.
    always_comb begin
        state_nxt = state;
        app_valid = 1'b0;
        app_data  = '0;
        start_pkt = 1'b0;
        hdr1_hs   = 1'b0;
        pop       = 1'b0;
        last_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (level >= LVL_W'(n_cand)) begin
                    start_pkt = 1'b1;
                    state_nxt = HDR0;
                end
            end
            HDR0: begin
                app_valid = 1'b1;
                app_data  = seq_r;
                if (app_ready) state_nxt = HDR1;
            end
            HDR1: begin
                app_valid = 1'b1;
                app_data  = make_hdr1(ovf_flag, 16'(n_lat));
                if (app_ready) begin
                    hdr1_hs   = 1'b1;
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                app_valid = 1'b1;
                app_data  = rd_data;
                if (app_ready) begin
                    pop = 1'b1;
                    if (remain == CNT_W'(1)) begin
                        last_pop  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Packet length latch and remaining-payload down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_lat   <= '0;
            remain  <= '0;
            app_len <= '0;
        end else if (start_pkt) begin
            n_lat   <= n_cand;
            remain  <= n_cand;
            app_len <= 16'((32'(n_cand) + 32'(HDR_WORDS)) << 2);
        end else if (pop) begin
            remain  <= remain - 1'b1;
        end
    end

    // Sequence number, written every cycle so it always tracks seq_nxt.
    always_ff @(posedge clk) begin
        if (rst) seq_r <= '0;
        else     seq_r <= seq_nxt;
    end

    // Sticky overflow flag and saturating drop counter; a drop coinciding
    // with the HDR1 handshake keeps the flag set for the following packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_flag <= 1'b0;
            ovf_cnt  <= '0;
        end else begin
            if (drop)         ovf_flag <= 1'b1;
            else if (hdr1_hs) ovf_flag <= 1'b0;
            if (drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule
